// File: rtl/alu_result_monitor_pkg.sv
// -----------------------------------------------------------------------------
// alu_result_monitor_pkg
// Shared definitions for the ALU result monitor: ALUOp encodings, record
// layout, monitor FSM state encoding, and the MISR step function used by the
// optional signature logic (enabled with the ALU_MON_MISR_EN macro).
// -----------------------------------------------------------------------------
package alu_result_monitor_pkg;

    localparam int ALUOP_W = 4;
    localparam int DATA_W  = 32;
    // Captured record: {ovf, aluop, result}
    localparam int REC_W   = DATA_W + ALUOP_W + 1;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD  = 4'd0,
        ALUOP_ADDU = 4'd1,
        ALUOP_SUB  = 4'd2,
        ALUOP_SUBU = 4'd3,
        ALUOP_AND  = 4'd4,
        ALUOP_OR   = 4'd5,
        ALUOP_NOR  = 4'd6,
        ALUOP_XOR  = 4'd7,
        ALUOP_SLL  = 4'd8,
        ALUOP_SRL  = 4'd9,
        ALUOP_SLT  = 4'd10,
        ALUOP_SLTU = 4'd11
    } aluop_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } mon_state_e;

    // One MISR clock: shift left, feed back the polynomial when the MSB
    // falls out, then fold in the new data word.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] data);
        logic [31:0] fb;
        fb = sig[31] ? MISR_POLY : 32'h0;
        return {sig[30:0], 1'b0} ^ fb ^ data;
    endfunction

endpackage

// File: rtl/alu_mon_fifo.sv
// -----------------------------------------------------------------------------
// alu_mon_fifo
// Synchronous FIFO with a registered head. rd_valid/rd_data are flops loaded
// from the next-state head, so a push into an empty FIFO shows up on rd_valid
// the cycle after the push edge. Pointers carry one extra wrap bit.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, wr_data      write request / record (accepted when !full)
//   full                no free slot (registered pointers only)
//   rd_en               reader accepts head (pop when rd_valid)
//   rd_valid, rd_data   registered head record
//   empty               no stored records
// -----------------------------------------------------------------------------
module alu_mon_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic             push, pop, empty_n;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = wr_en && !full;
    assign pop   = rd_en && rd_valid;

    assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
    assign empty_n  = (wr_ptr_n == rd_ptr_n);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            rd_valid <= !empty_n;
            // When the next head is the slot being written this edge, the
            // memory does not hold it yet: forward the write data instead.
            if (!empty_n) begin
                rd_data <= (rd_ptr_n == wr_ptr) ? wr_data : mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/alu_result_monitor.sv
// -----------------------------------------------------------------------------
// alu_result_monitor
// Capture side of the ALU interface. Records {ovf, aluop, result} pushed by the
// ALU stage are queued in alu_mon_fifo and handed to a reader over valid/ready.
// A session is armed by start and ends after CAP_LEN records or on stop; the
// FIFO is then drained and done is held until the next start.
// Optional feature: define ALU_MON_MISR_EN to add misr_sig, a 32-bit MISR over
// the accepted records of the current session.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   start, stop                      arm session / end session early (pulses)
//   in_valid/in_ready                record input handshake
//   in_aluop, in_result, in_ovf      record fields
//   out_valid/out_ready              head record handshake
//   out_aluop, out_result, out_ovf   registered head record
//   busy                             session is capturing
//   done                             session finished and FIFO drained
//   ovf_count                        saturating count of captured ovf records
//   misr_sig                         (ALU_MON_MISR_EN only) session signature
// -----------------------------------------------------------------------------
module alu_result_monitor
    import alu_result_monitor_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CAP_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluop,
    input  logic [31:0]      in_result,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_aluop,
    output logic [31:0]      out_result,
    output logic             out_ovf,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ovf_count
`ifdef ALU_MON_MISR_EN
    ,
    output logic [31:0]      misr_sig
`endif
);
    localparam logic [15:0]      CAP_LAST = 16'(CAP_LEN - 1);
    localparam logic [CNT_W-1:0] OVF_MAX  = '1;
    localparam logic [CNT_W-1:0] OVF_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    mon_state_e       state_q, state_d;
    logic             push, arm;
    logic             fifo_full, fifo_empty;
    logic [15:0]      captured;
    logic [REC_W-1:0] head;

    assign in_ready = (state_q == ST_CAPTURE) && !fifo_full;
    assign push     = in_valid && in_ready;
    assign arm      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign busy     = (state_q == ST_CAPTURE);
    assign done     = (state_q == ST_DONE);

    alu_mon_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  ({in_ovf, in_aluop, in_result}),
        .full     (fifo_full),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_data  (head),
        .empty    (fifo_empty)
    );

    assign out_ovf    = head[REC_W-1];
    assign out_aluop  = head[DATA_W +: ALUOP_W];
    assign out_result = head[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_CAPTURE;
            // A stop coinciding with the last push still accepts that push.
            ST_CAPTURE: if (stop || (push && captured == CAP_LAST)) state_d = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty) state_d = ST_DONE;
            ST_DONE:    if (start) state_d = ST_CAPTURE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured  <= '0;
            ovf_count <= '0;
        end else if (arm) begin
            captured  <= '0;
            ovf_count <= '0;
        end else if (push) begin
            captured <= captured + 16'd1;
            if (in_ovf && ovf_count != OVF_MAX) begin
                ovf_count <= ovf_count + OVF_ONE;
            end
        end
    end

`ifdef ALU_MON_MISR_EN
    // push only occurs in CAPTURE, so the signature is frozen elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr_sig <= '0;
        end else if (arm) begin
            misr_sig <= MISR_SEED;
        end else if (push) begin
            misr_sig <= misr_step(misr_sig, in_result ^ {27'b0, in_ovf, in_aluop});
        end
    end
`endif

endmodule
